// File: rtl/seg7_pkg.sv
// ============================================================================
// Module   : seg7_pkg
// Purpose  : Shared types and constants for the seven-segment capture block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_D2   = 2'd1,
    ST_D1   = 2'd2,
    ST_D0   = 2'd3
  } state_t;

  // Active-low common-anode segment codes indexed by hex value (dp bit set).
  localparam logic [15:0][7:0] c_SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  localparam logic [3:0] c_AN_DIG3  = 4'b0111;
  localparam logic [3:0] c_AN_DIG2  = 4'b1011;
  localparam logic [3:0] c_AN_DIG1  = 4'b1101;
  localparam logic [3:0] c_AN_DIG0  = 4'b1110;
  localparam logic [3:0] c_AN_BLANK = 4'b1111;

endpackage

`default_nettype wire

// File: rtl/seg7_decode.sv
// ============================================================================
// Module   : seg7_decode
// Purpose  : Combinational 7-bit segment pattern to {valid, hex} decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic       o_valid,
  output logic [3:0] o_hex
);

  always_comb begin
    o_valid = 1'b0;
    o_hex   = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if ({1'b1, i_seg} == c_SEG_TABLE[i]) begin
        o_valid = 1'b1;
        o_hex   = 4'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/seg7_capture.sv
// ============================================================================
// Module   : seg7_capture
// Purpose  : Snoops a multiplexed 4-digit display bus and recovers the number.
//            Optional dp capture enabled by macro SEG7_CAPTURE_DP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 3,
  parameter int BLANK_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  AN,
  input  logic [7:0]  BCD,
  output logic [15:0] number,
  output logic        frame_valid,
  output logic        changed,
  output logic        display_on,
  output logic        seg_error,
  output logic        seq_error
`ifdef SEG7_CAPTURE_DP_EN
  ,
  output logic [3:0]  dp
`endif
);

  localparam logic [8:0]  c_STABLE    = 9'(STABLE_CYCLES);
  localparam logic [15:0] c_BLANK_LIM = 16'(BLANK_TIMEOUT - 1);

  logic [3:0]  r_an;
  logic [7:0]  r_bcd;
  logic [8:0]  r_cnt;
  logic [15:0] r_blank;
  logic [3:0]  r_d3, r_d2, r_d1;
  state_t      r_state;
  state_t      w_state_next;

  logic        w_seg_ok;
  logic [3:0]  w_hex;
  logic        w_accept, w_blank, w_digit, w_expected;
  logic        w_is_d3, w_is_d2, w_is_d1, w_is_d0;
  logic        w_seg_err, w_seq_err, w_commit;
  logic        w_ld3, w_ld2, w_ld1;
  logic [15:0] w_frame;

  seg7_decode u_decode (
    .i_seg   (r_bcd[6:0]),
    .o_valid (w_seg_ok),
    .o_hex   (w_hex)
  );

  // The counter stops one past the threshold so a held pair fires exactly once.
  assign w_accept   = (r_cnt == c_STABLE);
  assign w_is_d3    = (r_an == c_AN_DIG3);
  assign w_is_d2    = (r_an == c_AN_DIG2);
  assign w_is_d1    = (r_an == c_AN_DIG1);
  assign w_is_d0    = (r_an == c_AN_DIG0);
  assign w_blank    = (r_an == c_AN_BLANK);
  assign w_digit    = w_is_d3 | w_is_d2 | w_is_d1 | w_is_d0;
  assign w_expected = ((r_state == ST_SYNC) && w_is_d3) ||
                      ((r_state == ST_D2)   && w_is_d2) ||
                      ((r_state == ST_D1)   && w_is_d1) ||
                      ((r_state == ST_D0)   && w_is_d0);
  assign w_frame    = {r_d3, r_d2, r_d1, w_hex};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_SYNC;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_seg_err    = 1'b0;
    w_seq_err    = 1'b0;
    w_commit     = 1'b0;
    w_ld3        = 1'b0;
    w_ld2        = 1'b0;
    w_ld1        = 1'b0;
    if (w_accept && !w_blank) begin
      if (!w_digit) begin
        w_seq_err    = 1'b1;
        w_state_next = ST_SYNC;
      end else begin
        w_seq_err = ~w_expected;
        w_seg_err = ~w_seg_ok;
        if (!w_seg_ok) begin
          w_state_next = ST_SYNC;
        end else if (w_is_d3) begin
          // digit3 always (re)starts a frame, in or out of order
          w_ld3        = 1'b1;
          w_state_next = ST_D2;
        end else if (!w_expected) begin
          w_state_next = ST_SYNC;
        end else begin
          case (r_state)
            ST_D2: begin
              w_ld2        = 1'b1;
              w_state_next = ST_D1;
            end
            ST_D1: begin
              w_ld1        = 1'b1;
              w_state_next = ST_D0;
            end
            ST_D0: begin
              w_commit     = 1'b1;
              w_state_next = ST_SYNC;
            end
            default: w_state_next = ST_SYNC;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_an        <= c_AN_BLANK;
      r_bcd       <= 8'hFF;
      r_cnt       <= 9'd0;
      r_blank     <= 16'd0;
      r_d3        <= 4'd0;
      r_d2        <= 4'd0;
      r_d1        <= 4'd0;
      number      <= 16'd0;
      frame_valid <= 1'b0;
      changed     <= 1'b0;
      display_on  <= 1'b0;
      seg_error   <= 1'b0;
      seq_error   <= 1'b0;
    end else begin
      r_an  <= AN;
      r_bcd <= BCD;
      if ({AN, BCD} == {r_an, r_bcd}) begin
        if (r_cnt <= c_STABLE) r_cnt <= r_cnt + 9'd1;
      end else begin
        r_cnt <= 9'd1;
      end

      if (!w_blank)              r_blank <= 16'd0;
      else if (r_blank != '1)    r_blank <= r_blank + 16'd1;

      // r_blank excludes the current cycle, hence the limit of timeout-1.
      if (w_accept && w_digit)                   display_on <= 1'b1;
      else if (w_blank && r_blank >= c_BLANK_LIM) display_on <= 1'b0;

      if (w_ld3) r_d3 <= w_hex;
      if (w_ld2) r_d2 <= w_hex;
      if (w_ld1) r_d1 <= w_hex;

      seg_error   <= w_seg_err;
      seq_error   <= w_seq_err;
      frame_valid <= w_commit;
      changed     <= w_commit && (w_frame != number);
      if (w_commit) number <= w_frame;
    end
  end

`ifdef SEG7_CAPTURE_DP_EN
  logic r_dp3, r_dp2, r_dp1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dp3 <= 1'b0;
      r_dp2 <= 1'b0;
      r_dp1 <= 1'b0;
      dp    <= 4'd0;
    end else begin
      if (w_ld3) r_dp3 <= ~r_bcd[7];
      if (w_ld2) r_dp2 <= ~r_bcd[7];
      if (w_ld1) r_dp1 <= ~r_bcd[7];
      if (w_commit) dp <= {r_dp3, r_dp2, r_dp1, ~r_bcd[7]};
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_seg7_capture.sv
// ============================================================================
// Module   : tb_seg7_capture
// Purpose  : Self-checking bench for seg7_capture against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_capture;

  localparam int STABLE  = 3;
  localparam int TIMEOUT = 64;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  AN    = 4'hF;
  logic [7:0]  BCD   = 8'hFF;
  logic [15:0] number;
  logic        frame_valid, changed, display_on, seg_error, seq_error;
`ifdef SEG7_CAPTURE_DP_EN
  logic [3:0]  dp;
`endif

  always #5 clk = ~clk;

  seg7_capture #(.STABLE_CYCLES(STABLE), .BLANK_TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .AN          (AN),
    .BCD         (BCD),
    .number      (number),
    .frame_valid (frame_valid),
    .changed     (changed),
    .display_on  (display_on),
    .seg_error   (seg_error),
    .seq_error   (seq_error)
`ifdef SEG7_CAPTURE_DP_EN
    ,
    .dp          (dp)
`endif
  );

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference model state: every registered sample since reset, plus the digits of the current frame.
  logic [11:0] hist[$];
  int          fq[$];
  int          fdp[$];
  logic [15:0] m_number;
  logic [3:0]  m_dp;
  logic        m_fv, m_ch, m_disp, m_segerr, m_seqerr;

  int n_tests = 0, n_fail = 0;
  int c_fv, c_ch, c_seg, c_seq;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int lookup(input logic [6:0] s);
    for (int i = 0; i < 16; i++) if (seg_tab[i][6:0] == s) return i;
    return -1;
  endfunction

  function automatic int an_idx(input logic [3:0] a);
    case (a)
      4'b0111: return 3;
      4'b1011: return 2;
      4'b1101: return 1;
      4'b1110: return 0;
      4'b1111: return -1;
      default: return -2;
    endcase
  endfunction

  function automatic logic [3:0] an_of(input int d);
    return ~(4'b0001 << d);
  endfunction

  task automatic model_reset();
    hist.delete(); fq.delete(); fdp.delete();
    m_number = 16'd0; m_dp = 4'd0;
    m_fv = 0; m_ch = 0; m_disp = 0; m_segerr = 0; m_seqerr = 0;
  endtask

  // Outputs after a clock edge, derived from the sample that was registered during the previous cycle.
  task automatic model_eval();
    int run, blanks, d, v;
    logic [11:0] cur;
    logic [15:0] nn;
    bit acc, expd;
    m_fv = 0; m_ch = 0; m_segerr = 0; m_seqerr = 0;
    if (hist.size() == 0) return;
    cur = hist[hist.size()-1];
    run = 0;
    for (int i = hist.size()-1; i >= 0 && hist[i] == cur; i--) run++;
    blanks = 0;
    for (int i = hist.size()-1; i >= 0 && hist[i][11:8] == 4'hF; i--) blanks++;
    acc = (run == STABLE);
    d   = an_idx(cur[11:8]);
    if (acc && d == -2) begin
      m_seqerr = 1; fq.delete(); fdp.delete();
    end else if (acc && d >= 0) begin
      m_disp   = 1;
      v        = lookup(cur[6:0]);
      expd     = (d == 3 - fq.size());
      m_seqerr = !expd;
      m_segerr = (v < 0);
      if (v < 0 || (!expd && d != 3)) begin
        fq.delete(); fdp.delete();
      end else begin
        if (d == 3) begin fq.delete(); fdp.delete(); end
        fq.push_back(v);
        fdp.push_back(int'(~cur[7]));
        if (fq.size() == 4) begin
          nn = {4'(fq[0]), 4'(fq[1]), 4'(fq[2]), 4'(fq[3])};
          m_fv = 1;
          m_ch = (nn != m_number);
          m_number = nn;
          m_dp = {1'(fdp[0]), 1'(fdp[1]), 1'(fdp[2]), 1'(fdp[3])};
          fq.delete(); fdp.delete();
        end
      end
    end else if (blanks >= TIMEOUT) begin
      m_disp = 0;
    end
  endtask

  task automatic tick(input logic [3:0] an, input logic [7:0] bcd);
    AN = an; BCD = bcd;
    @(posedge clk);
    model_eval();
    hist.push_back({an, bcd});
    @(negedge clk);
    chk("number", 32'(number), 32'(m_number));
    chk("frame_valid", 32'(frame_valid), 32'(m_fv));
    chk("changed", 32'(changed), 32'(m_ch));
    chk("display_on", 32'(display_on), 32'(m_disp));
    chk("seg_error", 32'(seg_error), 32'(m_segerr));
    chk("seq_error", 32'(seq_error), 32'(m_seqerr));
`ifdef SEG7_CAPTURE_DP_EN
    chk("dp", 32'(dp), 32'(m_dp));
`endif
    c_fv += int'(frame_valid); c_ch += int'(changed);
    c_seg += int'(seg_error);  c_seq += int'(seq_error);
  endtask

  task automatic hold(input logic [3:0] an, input logic [7:0] bcd, input int n);
    repeat (n) tick(an, bcd);
  endtask

  task automatic send_frame(input logic [15:0] num, input int n);
    logic [7:0] b;
    for (int d = 3; d >= 0; d--) begin
      b = seg_tab[num[d*4 +: 4]];
      b[7] = 1'($urandom_range(0, 1));
      hold(an_of(d), b, n);
    end
  endtask

  task automatic clr_counts();
    c_fv = 0; c_ch = 0; c_seg = 0; c_seq = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_number"}, 32'(number), 32'd0);
    chk({tag, "_fv"}, 32'(frame_valid), 32'd0);
    chk({tag, "_changed"}, 32'(changed), 32'd0);
    chk({tag, "_display"}, 32'(display_on), 32'd0);
    chk({tag, "_segerr"}, 32'(seg_error), 32'd0);
    chk({tag, "_seqerr"}, 32'(seq_error), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] num;
    logic [7:0]  b;
    logic [3:0]  a;
    model_reset();
    clr_counts();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b1;

    // steady 0x1234 traffic
    clr_counts();
    repeat (3) send_frame(16'h1234, 6);
    chk("run1234_commits", 32'(c_fv), 32'd3);
    chk("run1234_changed", 32'(c_ch), 32'd1);
    chk("run1234_number", 32'(number), 32'h1234);

    // value change between frames
    clr_counts();
    repeat (2) send_frame(16'hBEEF, 6);
    chk("beef_number", 32'(number), 32'hBEEF);
    chk("beef_changed", 32'(c_ch), 32'd1);

    // undecodable digit2 discards the frame
    clr_counts();
    hold(an_of(3), seg_tab[1], 6);
    hold(an_of(2), 8'hFF, 6);
    hold(an_of(1), seg_tab[3], 6);
    hold(an_of(0), seg_tab[4], 6);
    chk("segerr_pulses", 32'(c_seg), 32'd1);
    chk("segerr_nocommit", 32'(c_fv), 32'd0);
    clr_counts();
    send_frame(16'h1234, 6);
    chk("recover_number", 32'(number), 32'h1234);
    chk("recover_commit", 32'(c_fv), 32'd1);

    // skipped digit2, then illegal anode code
    clr_counts();
    hold(an_of(3), seg_tab[9], 6);
    hold(an_of(1), seg_tab[7], 6);
    hold(an_of(0), seg_tab[6], 6);
    chk("skip_nocommit", 32'(c_fv), 32'd0);
    chk("skip_seqerr_seen", 32'(c_seq >= 1), 32'd1);
    clr_counts();
    hold(4'b0011, seg_tab[5], 6);
    chk("badan_seqerr", 32'(c_seq), 32'd1);
    chk("badan_number", 32'(number), 32'h1234);

    // randomized traffic
    for (int s = 0; s < 200; s++) begin
      if ($urandom_range(0, 1) == 1) begin
        num = 16'($urandom);
        for (int d = 3; d >= 0; d--) begin
          b = seg_tab[num[d*4 +: 4]];
          b[7] = 1'($urandom_range(0, 1));
          hold(an_of(d), b, $urandom_range(3, 7));
          if ($urandom_range(0, 7) == 0) hold(4'hF, 8'hFF, $urandom_range(1, 4));
        end
      end else begin
        a = 4'($urandom);
        b = ($urandom_range(0, 1) == 1) ? seg_tab[$urandom_range(0, 15)] : 8'($urandom);
        hold(a, b, $urandom_range(1, 6));
      end
    end

    // blank timeout boundary
    send_frame(16'hA5C3, 6);
    hold(4'hF, 8'hFF, 63);
    hold(an_of(3), seg_tab[2], 6);
    chk("blank63_display", 32'(display_on), 32'd1);
    hold(4'hF, 8'hFF, 70);
    chk("blank70_display", 32'(display_on), 32'd0);

    // asynchronous reset while waiting for digit1
    hold(an_of(3), seg_tab[8], 6);
    hold(an_of(2), seg_tab[8], 4);
    reset = 1'b0;
    #1;
    chk_all_zero("midreset");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    clr_counts();
    hold(an_of(1), seg_tab[8], 6);
    hold(an_of(0), seg_tab[8], 6);
    chk("postreset_partial", 32'(c_fv), 32'd0);
    send_frame(16'h5A5A, 6);
    chk("postreset_commit", 32'(c_fv), 32'd1);
    chk("postreset_number", 32'(number), 32'h5A5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
